fft16_seq_ctrl: RTL

//  Sequencer for an in-place 16-point radix-2 DIF FFT built on one shared, pipelined butterfly unit.

---
 rtl/fft16_pkg.sv | 26 ++
 rtl/fft16_seq_ctrl_if.sv | 38 +++
 rtl/fft16_addr_gen.sv | 30 +++
 rtl/fft16_seq_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fft16_pkg.sv
// Shared constants, FSM state type and helpers for the 16-point FFT sequencer.
package fft16_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned LOG2N = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StDrain,
        StUnload
    } state_e;

    // One writeback pipeline slot: butterfly valid plus its two destination addresses.
    typedef struct packed {
        logic             v;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
    } wb_t;

    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft16_seq_ctrl_if.sv
// Control/handshake bundle between the FFT sequencer and its datapath/environment.
interface fft16_seq_ctrl_if;
    import fft16_pkg::*;

    logic             start;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic             ld_we;
    logic [LOG2N-1:0] ld_addr;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic             bf_valid;
    logic [2:0]       tw_idx;
    logic             bf_shift;
    logic [1:0]       stage;
    logic             wb_we;
    logic [LOG2N-1:0] wb_addr_a;
    logic [LOG2N-1:0] wb_addr_b;
    logic             out_valid;
    logic             out_ready;
    logic [LOG2N-1:0] out_idx;
    logic [LOG2N-1:0] out_addr;

    modport master (
        input  start, in_valid, out_ready,
        output busy, done, in_ready, ld_we, ld_addr, rd_addr_a, rd_addr_b, bf_valid, tw_idx,
               bf_shift, stage, wb_we, wb_addr_a, wb_addr_b, out_valid, out_idx, out_addr
    );

    modport slave (
        output start, in_valid, out_ready,
        input  busy, done, in_ready, ld_we, ld_addr, rd_addr_a, rd_addr_b, bf_valid, tw_idx,
               bf_shift, stage, wb_we, wb_addr_a, wb_addr_b, out_valid, out_idx, out_addr
    );

endinterface

// File: rtl/fft16_addr_gen.sv
// Radix-2 DIF operand addressing: maps (stage, butterfly k) to the in-place pair and twiddle.
module fft16_addr_gen
    import fft16_pkg::*;
(
    input  logic [1:0]       stage_i,
    input  logic [2:0]       k_i,
    output logic [LOG2N-1:0] a_o,
    output logic [LOG2N-1:0] b_o,
    output logic [2:0]       tw_o
);

    logic [3:0] span;
    logic [3:0] mask;
    logic [3:0] k4;
    logic [3:0] j;
    logic [3:0] tw4;

    // span is a power of two, so k/span and k%span reduce to masking.
    always_comb begin
        span = 4'd8 >> stage_i;
        mask = span - 4'd1;
        k4   = {1'b0, k_i};
        j    = k4 & mask;
        a_o  = ((k4 & ~mask) << 1) | j;
        b_o  = a_o | span;
        tw4  = j << stage_i;
        tw_o = tw4[2:0];
    end

endmodule

// File: rtl/fft16_seq_ctrl.sv
// Sequencer for an in-place 16-point radix-2 DIF FFT around one shared pipelined butterfly.
module fft16_seq_ctrl
    import fft16_pkg::*;
#(
    parameter int unsigned BF_LAT       = 2,
    parameter logic [3:0]  SCALE_STAGES = 4'b1111
) (
    input logic              clk,
    input logic              rst,
    fft16_seq_ctrl_if.master bus
);

    localparam int unsigned DrainW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    state_e            state_q;
    logic [LOG2N-1:0]  ld_cnt_q;
    logic [2:0]        k_q;
    logic [1:0]        stage_q;
    logic [DrainW-1:0] drain_q;
    logic [LOG2N-1:0]  out_n_q;
    logic              busy_q;
    logic              done_q;
    logic              in_ready_q;
    logic              bf_valid_q;
    logic              out_valid_q;
    wb_t               pipe_q [BF_LAT];

    logic [LOG2N-1:0]  ag_a;
    logic [LOG2N-1:0]  ag_b;
    logic [2:0]        ag_tw;

    fft16_addr_gen u_addr_gen (
        .stage_i (stage_q),
        .k_i     (k_q),
        .a_o     (ag_a),
        .b_o     (ag_b),
        .tw_o    (ag_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ld_cnt_q    <= '0;
            k_q         <= '0;
            stage_q     <= '0;
            drain_q     <= '0;
            out_n_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            bf_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !done_q) begin
                        state_q    <= StLoad;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        ld_cnt_q   <= '0;
                    end
                end
                StLoad: begin
                    if (bus.in_valid) begin
                        ld_cnt_q <= ld_cnt_q + 4'd1;
                        if (ld_cnt_q == 4'(N - 1)) begin
                            state_q    <= StIssue;
                            in_ready_q <= 1'b0;
                            bf_valid_q <= 1'b1;
                            k_q        <= '0;
                            stage_q    <= '0;
                        end
                    end
                end
                StIssue: begin
                    k_q <= k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_q    <= StDrain;
                        bf_valid_q <= 1'b0;
                        drain_q    <= '0;
                    end
                end
                StDrain: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == DrainW'(BF_LAT - 1)) begin
                        stage_q <= stage_q + 2'd1;
                        if (stage_q == 2'd3) begin
                            state_q     <= StUnload;
                            out_valid_q <= 1'b1;
                            out_n_q     <= '0;
                        end else begin
                            state_q    <= StIssue;
                            bf_valid_q <= 1'b1;
                        end
                    end
                end
                StUnload: begin
                    if (bus.out_ready) begin
                        out_n_q <= out_n_q + 4'd1;
                        if (out_n_q == 4'(N - 1)) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Free-running writeback delay line; never stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BF_LAT); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{v: bf_valid_q, a: bus.rd_addr_a, b: bus.rd_addr_b};
            for (int i = 1; i < int'(BF_LAT); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.ld_we     = bus.in_valid & in_ready_q;
    assign bus.ld_addr   = ld_cnt_q;
    assign bus.rd_addr_a = bf_valid_q ? ag_a : '0;
    assign bus.rd_addr_b = bf_valid_q ? ag_b : '0;
    assign bus.tw_idx    = bf_valid_q ? ag_tw : '0;
    assign bus.bf_valid  = bf_valid_q;
    assign bus.bf_shift  = SCALE_STAGES[stage_q];
    assign bus.stage     = stage_q;
    assign bus.wb_we     = pipe_q[BF_LAT-1].v;
    assign bus.wb_addr_a = pipe_q[BF_LAT-1].a;
    assign bus.wb_addr_b = pipe_q[BF_LAT-1].b;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_n_q;
    assign bus.out_addr  = bitrev4(out_n_q);

endmodule
